tdc_meas_sequencer: RTL and testbench
=====================================

// Module: tdc_meas_sequencer
// PURPOSE
//  Sequences the 32-tap TDC delay line: drives its start/stop inputs with a programmable gap,
//  waits for the line to settle, popcounts the captured thermometer word and averages 2^k samples.
//  Sits between the tile I/O (trigger/config) and the delay line; result_o feeds the byte readout mux.
// PARAMETERS
//  N_DELAY  32  delay-line taps = width of tdc_count_i
//  DLY_W    8   width of stop_dly_i (start->stop gap in clk cycles)
//  CNT_W    6   popcount width, $clog2(N_DELAY+1)
//  ACC_W    13  accumulator width, CNT_W+7 (max 128 samples)
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        reset, asynchronous, active-high (despite name)
//  trig_i       in   1        measurement request; rising edge starts a measurement
//  abort_i      in   1        synchronous abort, returns to IDLE
//  stop_dly_i   in   DLY_W    gap D between start and stop, latched at trigger
//  log2_samp_i  in   3        k, sample count N=2^k, latched at trigger
//  tdc_count_i  in   N_DELAY  thermometer word from delay line
//  tdc_start_o  out  1        start to delay line
//  tdc_stop_o   out  1        stop to delay line
//  busy_o       out  1        high whenever state != IDLE
//  done_o       out  1        one-cycle pulse, result_o valid/updated
//  ovf_o        out  1        last measurement saw an all-ones word (stop beyond line)
//  result_o     out  CNT_W    averaged tap count, acc >> k
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; acc, sample ctr, latched cfg, trig edge reg cleared.
//  - trig_i registered once; rise = trig_i & ~trig_q. Rise in IDLE (abort_i low) latches D, k
//    and enters START at that edge; acc, ovf flag, sample ctr cleared. Rises outside IDLE ignored.
//  - States/durations: START 1 -> WAIT D (skipped if D=0) -> STOP 1 -> SETTLE 2 -> CAPTURE 1
//    -> RECOVER 1 (back to START) if samples remain, else DONE 1 -> IDLE.
//  - tdc_start_o high in START..CAPTURE; tdc_stop_o high in STOP..CAPTURE; both low in
//    RECOVER/DONE/IDLE so the line re-arms. Outputs registered, aligned with state.
//  - CAPTURE: acc += popcount(tdc_count_i) (bubbles counted, no correction); if word is all
//    ones set internal ovf flag; sample ctr++. Last sample when ctr == 2^k-1.
//  - DONE: result_o <= acc >> k (truncate); ovf_o <= flag; done_o high this cycle only.
//    result_o/ovf_o hold until next DONE or reset.
//  - Latency: done_o rises at edge t + N*(D+6) - 1, t = edge sampling trig rise.
//  - abort_i high in any non-IDLE state: IDLE next edge, start/stop/busy low, no done_o,
//    result_o/ovf_o unchanged. abort_i and trig rise same cycle in IDLE: stay IDLE.
//  - acc cannot overflow: N*N_DELAY <= 2^ACC_W - 1. Wait counter counts down from D, no wrap.
//  - Reset mid-measurement: immediate return to reset values, incl. result_o.
// TESTING
//  - D=3,k=0, tdc_count_i=32'h0000_00FF -> done_o at t+8, result_o=8, ovf_o=0, stop high 4 cyc.
//  - D=0,k=2, counts 4,5,6,7 per CAPTURE -> result_o=5 (22>>2), done_o at t+23, 4 start pulses.
//  - k=0, tdc_count_i=32'hFFFF_FFFF -> result_o=32, ovf_o=1; next clean run clears ovf_o.
//  - abort_i pulse during WAIT of D=10 -> busy_o=0 next cycle, no done_o, result_o unchanged.
//  - trig_i held high / re-pulsed while busy -> exactly one measurement; re-arm needs low then high.
//  - rst_n asserted async during SETTLE -> all outputs 0 immediately; new trig works after release.

Source files
------------

// File: rtl/tdc_meas_sequencer.sv
// tdc_meas_sequencer: drives TDC start/stop with a programmable gap, popcounts the captured
// thermometer word and averages 2^k samples into result_o.
module tdc_meas_sequencer #(
    parameter int N_DELAY = 32,
    parameter int DLY_W   = 8,
    parameter int CNT_W   = 6,
    parameter int ACC_W   = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trig_i,
    input  logic               abort_i,
    input  logic [DLY_W-1:0]   stop_dly_i,
    input  logic [2:0]         log2_samp_i,
    input  logic [N_DELAY-1:0] tdc_count_i,
    output logic               tdc_start_o,
    output logic               tdc_stop_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               ovf_o,
    output logic [CNT_W-1:0]   result_o
);
    typedef enum logic [3:0] {
        S_IDLE, S_START, S_WAIT, S_STOP, S_SET1, S_SET2, S_CAP, S_REC, S_DONE
    } state_t;
    state_t state, state_nx;
    logic trig_q, rise, last, flag, flag_nx;
    logic [DLY_W-1:0] dly, wcnt;
    logic [2:0] k;
    logic [6:0] ctr;
    logic [CNT_W-1:0] pop;
    logic [ACC_W-1:0] acc, acc_nx;
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_DELAY; i++) pop = pop + CNT_W'(tdc_count_i[i]);
    end
    assign rise    = trig_i & ~trig_q;
    // k=7 wraps the shift to 0, so the compare value lands on 127 as required
    assign last    = ctr == (7'd1 << k) - 7'd1;
    assign acc_nx  = acc + ACC_W'(pop);
    assign flag_nx = flag | (&tdc_count_i);
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= S_IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (state != S_IDLE && abort_i) state_nx = S_IDLE;
        else begin
            case (state)
                S_IDLE:  state_nx = (rise && !abort_i) ? S_START : S_IDLE;
                S_START: state_nx = (dly == '0) ? S_STOP : S_WAIT;
                S_WAIT:  state_nx = (wcnt == DLY_W'(1)) ? S_STOP : S_WAIT;
                S_STOP:  state_nx = S_SET1;
                S_SET1:  state_nx = S_SET2;
                S_SET2:  state_nx = S_CAP;
                S_CAP:   state_nx = last ? S_DONE : S_REC;
                S_REC:   state_nx = S_START;
                default: state_nx = S_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tdc_start_o <= 1'b0;
            tdc_stop_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            tdc_start_o <= state_nx inside {S_START, S_WAIT, S_STOP, S_SET1, S_SET2, S_CAP};
            tdc_stop_o  <= state_nx inside {S_STOP, S_SET1, S_SET2, S_CAP};
            busy_o      <= state_nx != S_IDLE;
            done_o      <= state_nx == S_DONE;
        end
    end
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            trig_q   <= 1'b0;
            dly      <= '0;
            wcnt     <= '0;
            k        <= '0;
            ctr      <= '0;
            acc      <= '0;
            flag     <= 1'b0;
            ovf_o    <= 1'b0;
            result_o <= '0;
        end else begin
            trig_q <= trig_i;
            if (state == S_IDLE && rise && !abort_i) begin
                dly  <= stop_dly_i;
                k    <= log2_samp_i;
                ctr  <= '0;
                acc  <= '0;
                flag <= 1'b0;
            end
            if (state == S_START) wcnt <= dly;
            else if (state == S_WAIT) wcnt <= wcnt - DLY_W'(1);
            if (state == S_CAP) begin
                acc  <= acc_nx;
                flag <= flag_nx;
                ctr  <= ctr + 7'd1;
            end
            // the final sample is folded in on the same edge that enters DONE
            if (state_nx == S_DONE) begin
                result_o <= CNT_W'(acc_nx >> k);
                ovf_o    <= flag_nx;
            end
        end
    end
endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// tb_tdc_meas_sequencer: random and directed stimulus checked every cycle against a
// schedule-based model of the measurement sequence.
module tb_tdc_meas_sequencer;
    logic clk = 1'b0, rst_n, trig_i, abort_i;
    logic [7:0] stop_dly_i;
    logic [2:0] log2_samp_i;
    logic [31:0] tdc_count_i;
    logic tdc_start_o, tdc_stop_o, busy_o, done_o, ovf_o;
    logic [5:0] result_o;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    tdc_meas_sequencer dut (
        .clk(clk), .rst_n(rst_n), .trig_i(trig_i), .abort_i(abort_i),
        .stop_dly_i(stop_dly_i), .log2_samp_i(log2_samp_i), .tdc_count_i(tdc_count_i),
        .tdc_start_o(tdc_start_o), .tdc_stop_o(tdc_stop_o), .busy_o(busy_o),
        .done_o(done_o), .ovf_o(ovf_o), .result_o(result_o)
    );

    // Model: a measurement is a timeline of N*(D+6)-1 cycles after the trigger edge,
    // each sample occupying D+6 cycles with the capture at phase D+4.
    bit m_act, m_tq, m_flag, m_ovf;
    int m_o, m_d, m_k, m_len, m_sum, m_res;

    function automatic logic [31:0] therm(input int n);
        logic [31:0] all = '1;
        return n >= 32 ? all : (32'd1 << n) - 32'd1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic m_reset;
        m_act = 0; m_tq = 0; m_flag = 0; m_ovf = 0; m_res = 0; m_o = 0; m_sum = 0;
    endtask

    task automatic m_step;
        bit rise = trig_i & ~m_tq;
        m_tq = trig_i;
        if (m_act) begin
            if (abort_i) m_act = 0;
            else begin
                if (m_o < m_len && m_o % (m_d + 6) == m_d + 4) begin
                    m_sum += $countones(tdc_count_i);
                    m_flag |= &tdc_count_i;
                end
                m_o++;
                if (m_o == m_len) begin m_res = m_sum >> m_k; m_ovf = m_flag; end
                if (m_o > m_len) m_act = 0;
            end
        end else if (rise && !abort_i) begin
            m_act = 1; m_o = 0; m_d = stop_dly_i; m_k = log2_samp_i;
            m_len = (1 << m_k) * (m_d + 6) - 1; m_sum = 0; m_flag = 0;
        end
    endtask

    task automatic compare;
        int p = m_act ? m_o % (m_d + 6) : 0;
        bit run = m_act && m_o < m_len;
        chk("busy", 32'(busy_o), 32'(m_act));
        chk("done", 32'(done_o), 32'(m_act && m_o == m_len));
        chk("start", 32'(tdc_start_o), 32'(run && p <= m_d + 4));
        chk("stop", 32'(tdc_stop_o), 32'(run && p >= m_d + 1 && p <= m_d + 4));
        chk("result", 32'(result_o), 32'(m_res));
        chk("ovf", 32'(ovf_o), 32'(m_ovf));
    endtask

    task automatic cyc(input bit tr, input bit ab, input int d, input int k, input logic [31:0] cn);
        trig_i = tr; abort_i = ab; stop_dly_i = 8'(d); log2_samp_i = 3'(k); tdc_count_i = cn;
        @(posedge clk);
        m_step();
        #1 compare();
    endtask

    task automatic mid_reset;
        #2 rst_n = 1'b1;
        #1 m_reset();
        compare();
        @(posedge clk);
        #1 rst_n = 1'b0;
        compare();
    endtask

    task automatic run_meas(input string nm, input int d, input int k, input int base, input int step,
                            input int e_lat, input int e_res, input bit e_ovf, input int e_starts,
                            input int e_stops);
        int lat = -1, starts = 0, stops = 0;
        bit sp = 0;
        cyc(1, 0, d, k, therm(base));
        starts += tdc_start_o & ~sp; sp = tdc_start_o; stops += tdc_stop_o;
        for (int i = 1; i <= e_lat + 4; i++) begin
            cyc(0, 0, d, k, therm(base + step * ((i - 1) / (d + 6))));
            starts += tdc_start_o & ~sp; sp = tdc_start_o; stops += tdc_stop_o;
            if (done_o && lat < 0) lat = i;
        end
        chk({nm, " latency"}, 32'(lat), 32'(e_lat));
        chk({nm, " result"}, 32'(result_o), 32'(e_res));
        chk({nm, " ovf"}, 32'(ovf_o), 32'(e_ovf));
        chk({nm, " start pulses"}, 32'(starts), 32'(e_starts));
        chk({nm, " stop cycles"}, 32'(stops), 32'(e_stops));
    endtask

    initial begin
        int dones;
        rst_n = 1'b1; trig_i = 0; abort_i = 0; stop_dly_i = 0; log2_samp_i = 0; tdc_count_i = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 compare();
        chk("reset busy", 32'(busy_o), 0);
        chk("reset result", 32'(result_o), 0);
        rst_n = 1'b0;
        cyc(0, 0, 0, 0, 0);

        run_meas("d3k0", 3, 0, 8, 0, 8, 8, 0, 1, 4);
        run_meas("d0k2", 0, 2, 4, 1, 23, 5, 0, 4, 16);
        run_meas("allones", 2, 0, 32, 0, 7, 32, 1, 1, 4);
        run_meas("clean", 1, 1, 10, 0, 13, 10, 0, 2, 8);

        // abort during WAIT
        cyc(1, 0, 10, 0, therm(20));
        repeat (3) cyc(0, 0, 10, 0, therm(20));
        cyc(0, 1, 10, 0, therm(20));
        chk("abort busy", 32'(busy_o), 0);
        dones = 0;
        repeat (30) begin cyc(0, 0, 10, 0, therm(20)); dones += done_o; end
        chk("abort dones", 32'(dones), 0);
        chk("abort result", 32'(result_o), 10);

        // trigger held high, then re-pulsed while busy
        dones = 0;
        repeat (30) begin cyc(1, 0, 2, 0, therm(5)); dones += done_o; end
        chk("held dones", 32'(dones), 1);
        chk("held result", 32'(result_o), 5);
        dones = 0;
        cyc(0, 0, 2, 0, therm(6));
        cyc(1, 0, 2, 0, therm(6));
        cyc(0, 0, 2, 0, therm(6));
        cyc(1, 0, 2, 0, therm(6));
        repeat (20) begin cyc(0, 0, 2, 0, therm(6)); dones += done_o; end
        chk("repulse dones", 32'(dones), 1);

        // asynchronous reset while in SETTLE
        cyc(1, 0, 2, 0, therm(7));
        repeat (4) cyc(0, 0, 2, 0, therm(7));
        #2 rst_n = 1'b1;
        #1 m_reset();
        chk("arst start", 32'(tdc_start_o), 0);
        chk("arst stop", 32'(tdc_stop_o), 0);
        chk("arst busy", 32'(busy_o), 0);
        chk("arst result", 32'(result_o), 0);
        compare();
        @(posedge clk);
        #1 rst_n = 1'b0;
        run_meas("post_rst", 0, 0, 3, 0, 5, 3, 0, 1, 4);

        for (int n = 0; n < 4000; n++) begin
            int r = $urandom_range(0, 7);
            logic [31:0] cn = r == 0 ? '1 : r == 1 ? 32'($urandom) : therm($urandom_range(0, 32));
            int d = $urandom_range(0, 49) == 0 ? 255 : $urandom_range(0, 12);
            int k = $urandom_range(0, 29) == 0 ? 7 : $urandom_range(0, 3);
            if ($urandom_range(0, 999) == 0) mid_reset();
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 149) == 0, d, k, cn);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
